// File: rtl/systolic_pkg.sv
// Package: systolic_pkg
// Shared types and helpers for the systolic matrix-multiply feeder.
//   data_t          signed operand element
//   acc_t           signed result element (double width)
//   feeder_state_e  feeder FSM states
//   feed_len(size)  number of FEED steps for an array of the given size
// Configuration macro: FEEDER_SKEW_EN. When it is defined, the feeder targets a pipelined
// array and skews the lanes. When it is undefined, the lanes pass straight through.
package systolic_pkg;

    localparam int PKG_DATA_WIDTH = 8;

    typedef logic signed [PKG_DATA_WIDTH-1:0]   data_t;
    typedef logic signed [2*PKG_DATA_WIDTH-1:0] acc_t;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} feeder_state_e;

`ifdef FEEDER_SKEW_EN
    localparam bit SKEW_EN = 1'b1;
`else
    localparam bit SKEW_EN = 1'b0;
`endif

    // A skewed feed needs 2*(size-1) extra steps so that the last operand can enter the
    // farthest lane.
    function automatic int feed_len(input int size);
        return SKEW_EN ? (3 * size - 2) : size;
    endfunction

endpackage

// File: rtl/systolic_feed_sel.sv
// Module: systolic_feed_sel
// Selects the operand that each lane receives at feed step `step`.
// Lane r takes mat[r][step - r] when the feed is skewed, and mat[r][step] when it is not.
// Any position outside the matrix gives zero.
// The B operand reuses this module through a transposed view of the matrix.
//   step   in   STEP_W                 current feed step k
//   mat    in   [SIZE][SIZE]xDATA_WIDTH latched matrix, mat[lane][index]
//   lanes  out  [SIZE]xDATA_WIDTH      per-lane operand for step k
// Configuration macro: FEEDER_SKEW_EN (through systolic_pkg::SKEW_EN).
module systolic_feed_sel
    import systolic_pkg::*;
#(
    parameter int SIZE       = 3,
    parameter int DATA_WIDTH = 8,
    parameter int STEP_W     = 4
) (
    input  logic [STEP_W-1:0]                          step,
    input  logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0]  mat,
    output logic [SIZE-1:0][DATA_WIDTH-1:0]            lanes
);

    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    for (genvar r = 0; r < SIZE; r++) begin : g_lane
        int                    idx;
        logic [DATA_WIDTH-1:0] lane_val;

        // NOTE: every output of a combinational block gets a default first, so no path
        // can hold its old value and infer a latch.
        always_comb begin
            lane_val = '0;
            idx      = int'(step) - (SKEW_EN ? r : 0);
            if (idx >= 0 && idx < SIZE) begin
                lane_val = mat[r][idx[IDX_W-1:0]];
            end
        end

        assign lanes[r] = lane_val;
    end

endmodule

// File: rtl/systolic_feeder.sv
// Module: systolic_feeder
// Feeds operands to a SIZE x SIZE systolic matrix-multiply array and collects the result.
// It accepts A and B through a valid/ready handshake and clears the array for one cycle.
// Next, it streams A columns and B rows into the array lanes and waits DRAIN_CYCLES.
// It then captures C and presents it through a valid/ready handshake.
//   clk          in   1                          clock
//   rst          in   1                          asynchronous reset, active high
//   start_valid  in   1                          A/B matrices presented
//   start_ready  out  1                          idle, will accept matrices
//   a_mat        in   [SIZE][SIZE]xDATA_WIDTH    signed A, a_mat[row][col]
//   b_mat        in   [SIZE][SIZE]xDATA_WIDTH    signed B, b_mat[row][col]
//   arr_clear    out  1                          zeroes the array accumulators
//   arr_a        out  [SIZE]xDATA_WIDTH          array A_in lanes (one per row)
//   arr_b        out  [SIZE]xDATA_WIDTH          array B_in lanes (one per column)
//   arr_c        in   [SIZE][SIZE]x2*DATA_WIDTH  array C_out
//   res_valid    out  1                          res_c holds a completed product
//   res_ready    in   1                          consumer accepts res_c
//   res_c        out  [SIZE][SIZE]x2*DATA_WIDTH  captured C = A*B (wrapping)
// Configuration macro: FEEDER_SKEW_EN. It selects skewed lanes for a pipelined array, with
// 3*SIZE-2 feed steps. When it is undefined, the feed has SIZE plain steps.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int SIZE         = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start_valid,
    output logic                                         start_ready,
    input  logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0]    a_mat,
    input  logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0]    b_mat,
    output logic                                         arr_clear,
    output logic [SIZE-1:0][DATA_WIDTH-1:0]              arr_a,
    output logic [SIZE-1:0][DATA_WIDTH-1:0]              arr_b,
    input  logic [SIZE-1:0][SIZE-1:0][2*DATA_WIDTH-1:0]  arr_c,
    output logic                                         res_valid,
    input  logic                                         res_ready,
    output logic [SIZE-1:0][SIZE-1:0][2*DATA_WIDTH-1:0]  res_c
);

    localparam int F       = feed_len(SIZE);
    localparam int STEP_W  = $clog2(3 * SIZE);
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [STEP_W-1:0]  LAST_STEP  = STEP_W'(F - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(DRAIN_CYCLES - 1);

    feeder_state_e state, state_next;

    logic [STEP_W-1:0]  step_q, step_next;
    logic [DRAIN_W-1:0] drain_q, drain_next;
    logic               load;
    logic               capture;

    logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0] a_q;
    logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0] b_q;
    logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0] b_t;
    logic [SIZE-1:0][DATA_WIDTH-1:0]           sel_a;
    logic [SIZE-1:0][DATA_WIDTH-1:0]           sel_b;

    // B lane j walks down column j, so the selector sees B transposed: b_t[j][r] = B[r][j].
    for (genvar j = 0; j < SIZE; j++) begin : g_tr_col
        for (genvar r = 0; r < SIZE; r++) begin : g_tr_row
            assign b_t[j][r] = b_q[r][j];
        end
    end

    // The selectors look at the step of the next cycle, so the registered lanes line up
    // with the FEED state that holds that step.
    systolic_feed_sel #(
        .SIZE       (SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .STEP_W     (STEP_W)
    ) u_sel_a (
        .step  (step_next),
        .mat   (a_q),
        .lanes (sel_a)
    );

    systolic_feed_sel #(
        .SIZE       (SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .STEP_W     (STEP_W)
    ) u_sel_b (
        .step  (step_next),
        .mat   (b_t),
        .lanes (sel_b)
    );

    always_comb begin
        state_next = state;
        step_next  = step_q;
        drain_next = drain_q;
        load       = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (start_valid) begin
                    load       = 1'b1;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                step_next  = '0;
                state_next = FEED;
            end
            FEED: begin
                // The counter stops at the last step rather than wrapping.
                if (step_q == LAST_STEP) begin
                    drain_next = '0;
                    state_next = DRAIN;
                end else begin
                    step_next = step_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == LAST_DRAIN) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else begin
                    drain_next = drain_q + 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments. Every register then samples
    // values from before the edge, whatever order the statements appear in.
    // NOTE: the operand and result registers are explicitly reset. This clears any
    // half-fed operands and leaves res_c at zero after a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            step_q  <= '0;
            drain_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            arr_a   <= '0;
            arr_b   <= '0;
            res_c   <= '0;
        end else begin
            state   <= state_next;
            step_q  <= step_next;
            drain_q <= drain_next;
            if (load) begin
                a_q <= a_mat;
                b_q <= b_mat;
            end
            arr_a <= (state_next == FEED) ? sel_a : '0;
            arr_b <= (state_next == FEED) ? sel_b : '0;
            if (capture) begin
                res_c <= arr_c;
            end
        end
    end

    assign start_ready = (state == IDLE);
    assign arr_clear   = (state == CLEAR);
    assign res_valid   = (state == DONE);

endmodule

// File: tb/tb_systolic_feeder.sv
// Testbench: tb_systolic_feeder
// Drives systolic_feeder through a behavioural model of the array that it feeds.
// The model is a plain accumulator array when FEEDER_SKEW_EN is undefined, and a
// register-per-hop pipelined array when FEEDER_SKEW_EN is defined. Expected products come
// from a direct matrix multiply, wrapped to 2*DW bits. Expected lanes come from the index rule.
module tb_systolic_feeder;

    localparam int SIZE = 3;
    localparam int DW   = 8;
`ifdef FEEDER_SKEW_EN
    localparam bit SKEW = 1'b1;
`else
    localparam bit SKEW = 1'b0;
`endif
    localparam int F   = SKEW ? (3 * SIZE - 2) : SIZE;
    localparam int LAT = 1 + F + 1;

    typedef logic [SIZE-1:0][SIZE-1:0][DW-1:0]   mat_t;
    typedef logic [SIZE-1:0][SIZE-1:0][2*DW-1:0] res_t;
    typedef logic [SIZE-1:0][DW-1:0]             lane_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  start_valid;
    logic  start_ready;
    mat_t  a_mat;
    mat_t  b_mat;
    logic  arr_clear;
    lane_t arr_a;
    lane_t arr_b;
    res_t  arr_c;
    logic  res_valid;
    logic  res_ready;
    res_t  res_c;

    int vectors     = 0;
    int miscompares = 0;

    mat_t  cur_a;
    mat_t  cur_b;
    lane_t log_a [64];
    lane_t log_b [64];

    always #5 clk = ~clk;

    systolic_feeder #(
        .SIZE         (SIZE),
        .DATA_WIDTH   (DW),
        .DRAIN_CYCLES (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_mat       (a_mat),
        .b_mat       (b_mat),
        .arr_clear   (arr_clear),
        .arr_a       (arr_a),
        .arr_b       (arr_b),
        .arr_c       (arr_c),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_c       (res_c)
    );

    // ---------------- behavioural array model ----------------
    res_t       acc_m = '0;
    logic [DW-1:0] pa   [SIZE][SIZE];
    logic [DW-1:0] pb   [SIZE][SIZE];
    logic [DW-1:0] a_in [SIZE][SIZE];
    logic [DW-1:0] b_in [SIZE][SIZE];

    function automatic logic [2*DW-1:0] mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[2*DW-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            a_in[i][0] = arr_a[i];
            b_in[0][i] = arr_b[i];
            for (int j = 1; j < SIZE; j++) begin
                a_in[i][j] = SKEW ? pa[i][j-1] : arr_a[i];
                b_in[j][i] = SKEW ? pb[j-1][i] : arr_b[i];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                if (arr_clear) begin
                    acc_m[i][j] <= '0;
                    pa[i][j]    <= '0;
                    pb[i][j]    <= '0;
                end else begin
                    acc_m[i][j] <= acc_m[i][j] + mul(a_in[i][j], b_in[i][j]);
                    pa[i][j]    <= a_in[i][j];
                    pb[i][j]    <= b_in[i][j];
                end
            end
        end
    end

    assign arr_c = acc_m;

    // ---------------- reference helpers ----------------
    function automatic res_t exp_prod(input mat_t a, input mat_t b);
        res_t r = '0;
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                int s = 0;
                for (int m = 0; m < SIZE; m++) begin
                    s += int'($signed(a[i][m])) * int'($signed(b[m][j]));
                end
                r[i][j] = s[2*DW-1:0];
            end
        end
        return r;
    endfunction

    function automatic lane_t exp_lane_a(input mat_t a, input int k);
        lane_t l = '0;
        for (int i = 0; i < SIZE; i++) begin
            int m = SKEW ? (k - i) : k;
            if (m >= 0 && m < SIZE) l[i] = a[i][m];
        end
        return l;
    endfunction

    function automatic lane_t exp_lane_b(input mat_t b, input int k);
        lane_t l = '0;
        for (int j = 0; j < SIZE; j++) begin
            int m = SKEW ? (k - j) : k;
            if (m >= 0 && m < SIZE) l[j] = b[m][j];
        end
        return l;
    endfunction

    function automatic mat_t seq_mat();
        mat_t m;
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                m[r][c] = DW'(r * SIZE + c + 1);
        return m;
    endfunction

    function automatic mat_t ident(input int scale);
        mat_t m = '0;
        for (int r = 0; r < SIZE; r++) m[r][r] = DW'(scale);
        return m;
    endfunction

    function automatic mat_t fill(input logic [DW-1:0] v);
        mat_t m;
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                m[r][c] = v;
        return m;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                m[r][c] = DW'($urandom);
        return m;
    endfunction

    // ---------------- checking tasks ----------------
    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the falling edge just after the acceptance edge (c = 0, CLEAR cycle).
    // Walks cycle by cycle until res_valid, checking clear and lane values each cycle.
    task automatic wait_result(input string tag, output int lat, output int clears);
        int c = 0;
        clears = 0;
        while (c < 200) begin
            lane_t ea = '0;
            lane_t eb = '0;
            if (c >= 1 && c <= F) begin
                ea = exp_lane_a(cur_a, c - 1);
                eb = exp_lane_b(cur_b, c - 1);
            end
            if (c < 64) begin
                log_a[c] = arr_a;
                log_b[c] = arr_b;
            end
            if (arr_clear) clears++;
            if (c <= LAT) begin
                check($sformatf("%s clear c%0d", tag, c), arr_clear, (c == 0));
                check($sformatf("%s arr_a c%0d", tag, c), arr_a, ea);
                check($sformatf("%s arr_b c%0d", tag, c), arr_b, eb);
            end
            if (res_valid) break;
            @(posedge clk);
            @(negedge clk);
            c++;
        end
        lat = c;
        check({tag, " res_valid timeout"}, res_valid, 1'b1);
    endtask

    task automatic start_run(input mat_t a, input mat_t b);
        a_mat = a;
        b_mat = b;
        cur_a = a;
        cur_b = b;
        start_valid = 1'b1;
        check("start_ready idle", start_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check("res_valid drop", res_valid, 1'b0);
        check("start_ready back", start_ready, 1'b1);
    endtask

    task automatic run_check(input string tag, input mat_t a, input mat_t b);
        int lat, clears;
        start_run(a, b);
        wait_result(tag, lat, clears);
        check({tag, " latency"}, lat, LAT);
        check({tag, " clears"}, clears, 1);
        check({tag, " res_c"}, res_c, exp_prod(a, b));
        handshake();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   lat, clears;
        res_t held;
        mat_t a2, b2;

        rst         = 1'b1;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        a_mat       = '0;
        b_mat       = '0;
        cur_a       = '0;
        cur_b       = '0;
        repeat (2) @(negedge clk);
        check("rst start_ready", start_ready, 1'b1);
        check("rst arr_clear", arr_clear, 1'b0);
        check("rst arr_a", arr_a, '0);
        check("rst arr_b", arr_b, '0);
        check("rst res_valid", res_valid, 1'b0);
        check("rst res_c", res_c, '0);
        rst = 1'b0;
        @(negedge clk);

        // Identity times 1..9 gives 1..9 back.
        run_check("ident", ident(1), seq_mat());
        check("ident res_c const", res_c, res_t'(exp_prod(ident(1), seq_mat())));

        // Lane trace with A = B = 1..9.
        run_check("seq", seq_mat(), seq_mat());
`ifdef FEEDER_SKEW_EN
        check("trace a k0", log_a[1], {8'd0, 8'd0, 8'd1});
        check("trace b k0", log_b[1], {8'd0, 8'd0, 8'd1});
        check("trace a k2", log_a[3], {8'd7, 8'd5, 8'd3});
        check("trace b k2", log_b[3], {8'd3, 8'd5, 8'd7});
        check("trace a k4", log_a[5], {8'd9, 8'd0, 8'd0});
        check("trace a k6", log_a[7], '0);
`else
        check("trace a k0", log_a[1], {8'd7, 8'd4, 8'd1});
        check("trace b k0", log_b[1], {8'd3, 8'd2, 8'd1});
`endif

        // Most negative operands: 3 * 16384 wraps to 16'hC000.
        start_run(fill(8'h80), fill(8'h80));
        wait_result("neg", lat, clears);
        check("neg latency", lat, LAT);
        check("neg res_c", res_c, exp_prod(fill(8'h80), fill(8'h80)));
        check("neg elem", res_c[1][2], 16'hC000);

        // Consumer stalls for 10 cycles in DONE while start_valid toggles.
        held = res_c;
        for (int i = 0; i < 10; i++) begin
            start_valid = i[0];
            @(posedge clk);
            @(negedge clk);
            check($sformatf("hold valid %0d", i), res_valid, 1'b1);
            check($sformatf("hold ready %0d", i), start_ready, 1'b0);
            check($sformatf("hold res_c %0d", i), res_c, held);
        end
        start_valid = 1'b0;
        handshake();
        @(posedge clk);
        @(negedge clk);
        check("no stray start", arr_clear, 1'b0);
        check("still idle", start_ready, 1'b1);

        // Random operands.
        for (int i = 0; i < 4; i++) begin
            run_check($sformatf("rand%0d", i), rand_mat(), rand_mat());
        end

        // Reset during FEED step 1.
        start_run(rand_mat(), rand_mat());
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("midrst async start_ready", start_ready, 1'b1);
        check("midrst async arr_a", arr_a, '0);
        @(posedge clk);
        @(negedge clk);
        check("midrst start_ready", start_ready, 1'b1);
        check("midrst arr_clear", arr_clear, 1'b0);
        check("midrst arr_a", arr_a, '0);
        check("midrst arr_b", arr_b, '0);
        check("midrst res_valid", res_valid, 1'b0);
        check("midrst res_c", res_c, '0);
        rst = 1'b0;
        @(negedge clk);
        run_check("after rst", ident(2), seq_mat());

        // Back-to-back with start_valid and res_ready held high.
        a2 = rand_mat();
        b2 = rand_mat();
        a_mat = seq_mat();
        b_mat = fill(8'hFF);
        cur_a = a_mat;
        cur_b = b_mat;
        start_valid = 1'b1;
        res_ready   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wait_result("b2b1", lat, clears);
        check("b2b1 latency", lat, LAT);
        check("b2b1 clears", clears, 1);
        check("b2b1 res_c", res_c, exp_prod(seq_mat(), fill(8'hFF)));
        a_mat = a2;
        b_mat = b2;
        cur_a = a2;
        cur_b = b2;
        @(posedge clk);
        @(negedge clk);
        check("b2b idle valid", res_valid, 1'b0);
        check("b2b idle ready", start_ready, 1'b1);
        check("b2b idle clear", arr_clear, 1'b0);
        @(posedge clk);
        @(negedge clk);
        wait_result("b2b2", lat, clears);
        check("b2b2 latency", lat, LAT);
        check("b2b2 clears", clears, 1);
        check("b2b2 res_c", res_c, exp_prod(a2, b2));
        start_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check("b2b end ready", start_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("b2b end clear", arr_clear, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
